// File: rtl/apb_gpio_ext_pkg.sv
// Shared constants, register indices and byte-strobe merge helpers for apb_gpio_ext.
package apb_gpio_ext_pkg;

  localparam int unsigned PADDR_W = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [IDX_W-1:0] {
    IDX_MODE        = 4'd0,
    IDX_DIR         = 4'd1,
    IDX_OUT         = 4'd2,
    IDX_IN          = 4'd3,
    IDX_OUT_SET     = 4'd4,
    IDX_OUT_CLR     = 4'd5,
    IDX_OUT_TGL     = 4'd6,
    IDX_TR_TYPE     = 4'd7,
    IDX_TR_LVL0     = 4'd8,
    IDX_TR_LVL1     = 4'd9,
    IDX_TR_STAT     = 4'd10,
    IDX_IRQ_ENA     = 4'd11,
    IDX_DB_ENA      = 4'd12,
    IDX_DB_PRESCALE = 4'd13,
    IDX_IRQ_STAT    = 4'd14
  } reg_idx_e;

  function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < int'(STRB_W); i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] merge_write(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
    return (old & ~strb_mask(strb)) | (data & strb_mask(strb));
  endfunction

  function automatic logic [DATA_W-1:0] merge_set(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
    return old | (data & strb_mask(strb));
  endfunction

  function automatic logic [DATA_W-1:0] merge_clr(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
    return old & ~(data & strb_mask(strb));
  endfunction

  function automatic logic [DATA_W-1:0] merge_tgl(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
    return old ^ (data & strb_mask(strb));
  endfunction

  function automatic logic [DATA_W-1:0] merge_w1c(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb);
    return old & ~(data & strb_mask(strb));
  endfunction

endpackage

// File: rtl/apb_gpio_ext_if.sv
// APB3 completer-side bundle for apb_gpio_ext.
interface apb_gpio_ext_if;
  import apb_gpio_ext_pkg::*;

  logic               PSEL;
  logic               PENABLE;
  logic [PADDR_W-1:0] PADDR;
  logic               PWRITE;
  logic [STRB_W-1:0]  PSTRB;
  logic [DATA_W-1:0]  PWDATA;
  logic [DATA_W-1:0]  PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport master (output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/gpio_debounce.sv
// Prescaled per-pin debounce filter feeding the IN register; bypassed per pin when disabled.
module gpio_debounce #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DB_SAMPLES = 4,
  parameter int unsigned DB_PRESC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      synced,
  input  logic [WIDTH-1:0]      db_ena,
  input  logic [DB_PRESC_W-1:0] presc,
  input  logic                  presc_restart,
  output logic [WIDTH-1:0]      in_q
);

  localparam int unsigned      CNT_W    = $clog2(DB_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_SAMPLES - 1);

  logic [DB_PRESC_W-1:0] presc_cnt;
  logic [WIDTH-1:0]      ena_q;
  logic [CNT_W-1:0]      cnt [WIDTH];
  logic                  tick_c;

  assign tick_c = (presc_cnt == presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      ena_q     <= '0;
      in_q      <= '0;
      for (int n = 0; n < int'(WIDTH); n++) cnt[n] <= '0;
    end else begin
      presc_cnt <= (presc_restart || tick_c) ? '0 : presc_cnt + DB_PRESC_W'(1);
      ena_q     <= db_ena;
      for (int n = 0; n < int'(WIDTH); n++) begin
        // An enable change always restarts the pin's sample count.
        if (!db_ena[n] || (db_ena[n] != ena_q[n])) begin
          cnt[n] <= '0;
          if (!db_ena[n]) in_q[n] <= synced[n];
        end else if (synced[n] == in_q[n]) begin
          cnt[n] <= '0;
        end else if (tick_c) begin
          if (cnt[n] == CNT_LAST) begin
            in_q[n] <= ~in_q[n];
            cnt[n]  <= '0;
          end else begin
            cnt[n] <= cnt[n] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/apb_gpio_ext.sv
// APB3 GPIO with atomic output aliases, debounced inputs, edge/level triggers and masked IRQ.
module apb_gpio_ext
  import apb_gpio_ext_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH   = 32,
  parameter int unsigned INPUT_STAGES = 2,
  parameter int unsigned DB_SAMPLES   = 4,
  parameter int unsigned DB_PRESC_W   = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_gpio_ext_if.slave         bus,
  output logic                  irq_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe
);

  localparam logic [DATA_W-1:0] PIN_MASK = DATA_W'((64'(1) << GPIO_WIDTH) - 64'(1));

  logic [DATA_W-1:0] mode, dir, out_r, tr_type, tr_lvl0, tr_lvl1, tr_stat, irq_ena, db_ena, dly;
  logic [DB_PRESC_W-1:0] db_presc;
  logic [DATA_W-1:0]     prdata;
  logic                  pslverr;

  logic [GPIO_WIDTH-1:0] sync_q [INPUT_STAGES];
  logic [GPIO_WIDTH-1:0] in_q;
  logic [DATA_W-1:0]     in_ext, hit_c, rdata_c;
  logic                  err_c, setup_c, wr_c, presc_restart_c, addr_lsb_unused;
  reg_idx_e              idx;

  assign idx             = reg_idx_e'(bus.PADDR[PADDR_W-1:2]);
  assign addr_lsb_unused = ^bus.PADDR[1:0];
  assign setup_c         = bus.PSEL & ~bus.PENABLE;
  assign wr_c            = bus.PSEL & bus.PENABLE & bus.PWRITE & ~err_c;
  assign presc_restart_c = wr_c & (idx == IDX_DB_PRESCALE);
  assign in_ext          = DATA_W'(in_q);

  assign bus.PRDATA  = prdata;
  assign bus.PSLVERR = pslverr;
  assign bus.PREADY  = 1'b1;

  // Read mux and illegal-access decode.
  always_comb begin
    err_c   = 1'b0;
    rdata_c = '0;
    case (idx)
      IDX_MODE:        rdata_c = mode;
      IDX_DIR:         rdata_c = dir;
      IDX_OUT:         rdata_c = out_r;
      IDX_IN:          begin rdata_c = in_ext; err_c = bus.PWRITE; end
      IDX_OUT_SET,
      IDX_OUT_CLR,
      IDX_OUT_TGL:     err_c = ~bus.PWRITE;
      IDX_TR_TYPE:     rdata_c = tr_type;
      IDX_TR_LVL0:     rdata_c = tr_lvl0;
      IDX_TR_LVL1:     rdata_c = tr_lvl1;
      IDX_TR_STAT:     rdata_c = tr_stat;
      IDX_IRQ_ENA:     rdata_c = irq_ena;
      IDX_DB_ENA:      rdata_c = db_ena;
      IDX_DB_PRESCALE: rdata_c = DATA_W'(db_presc);
      IDX_IRQ_STAT:    begin rdata_c = tr_stat & irq_ena; err_c = bus.PWRITE; end
      default:         err_c = 1'b1;
    endcase
  end

  assign hit_c = (~tr_type & ((tr_lvl0 & ~in_ext) | (tr_lvl1 & in_ext)))
               | ( tr_type & ((tr_lvl0 & dly & ~in_ext) | (tr_lvl1 & ~dly & in_ext)));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int s = 0; s < int'(INPUT_STAGES); s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int s = 1; s < int'(INPUT_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  gpio_debounce #(
    .WIDTH      (GPIO_WIDTH),
    .DB_SAMPLES (DB_SAMPLES),
    .DB_PRESC_W (DB_PRESC_W)
  ) u_debounce (
    .clk           (PCLK),
    .rst           (PRESET),
    .synced        (sync_q[INPUT_STAGES-1]),
    .db_ena        (db_ena[GPIO_WIDTH-1:0]),
    .presc         (db_presc),
    .presc_restart (presc_restart_c),
    .in_q          (in_q)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      {mode, dir, out_r, tr_type, tr_lvl0, tr_lvl1} <= '0;
      {tr_stat, irq_ena, db_ena, dly, prdata}       <= '0;
      db_presc <= '0;
      pslverr  <= 1'b0;
      irq_o    <= 1'b0;
      gpio_o   <= '0;
      gpio_oe  <= '0;
    end else begin
      dly     <= in_ext;
      irq_o   <= |(tr_stat & irq_ena);
      gpio_o  <= GPIO_WIDTH'(~mode & out_r);
      gpio_oe <= GPIO_WIDTH'(dir & ~(mode & out_r));
      tr_stat <= (tr_stat | hit_c) & PIN_MASK;
      pslverr <= setup_c & err_c;
      if (setup_c && !bus.PWRITE) prdata <= rdata_c;
      if (wr_c) begin
        case (idx)
          IDX_MODE:        mode    <= merge_write(mode, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_DIR:         dir     <= merge_write(dir, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_OUT:         out_r   <= merge_write(out_r, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_OUT_SET:     out_r   <= merge_set(out_r, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_OUT_CLR:     out_r   <= merge_clr(out_r, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_OUT_TGL:     out_r   <= merge_tgl(out_r, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_TR_TYPE:     tr_type <= merge_write(tr_type, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_TR_LVL0:     tr_lvl0 <= merge_write(tr_lvl0, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_TR_LVL1:     tr_lvl1 <= merge_write(tr_lvl1, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          // A new hit in the same cycle overrides the clear.
          IDX_TR_STAT:     tr_stat <= (merge_w1c(tr_stat, bus.PWDATA, bus.PSTRB) | hit_c) & PIN_MASK;
          IDX_IRQ_ENA:     irq_ena <= merge_write(irq_ena, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_DB_ENA:      db_ena  <= merge_write(db_ena, bus.PWDATA, bus.PSTRB) & PIN_MASK;
          IDX_DB_PRESCALE: db_presc <= DB_PRESC_W'(merge_write(DATA_W'(db_presc), bus.PWDATA, bus.PSTRB));
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_gpio_ext.sv
// Directed testbench for apb_gpio_ext: a 32-pin instance plus an 8-pin instance for width masking.
module tb_apb_gpio_ext;

  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, tgt8 = 1'b0;
  logic [5:0]  paddr = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] gpio_i = '0;
  logic [7:0]  gpio8_i = '0;
  wire  [31:0] gpio_o, gpio_oe;
  wire  [7:0]  gpio8_o, gpio8_oe;
  wire         irq, irq8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] d;
  logic        e;

  always #5 clk = ~clk;

  apb_gpio_ext_if bus ();
  apb_gpio_ext_if bus8 ();

  assign bus.PSEL     = psel & ~tgt8;
  assign bus.PENABLE  = penable;
  assign bus.PADDR    = paddr;
  assign bus.PWRITE   = pwrite;
  assign bus.PSTRB    = pstrb;
  assign bus.PWDATA   = pwdata;
  assign bus8.PSEL    = psel & tgt8;
  assign bus8.PENABLE = penable;
  assign bus8.PADDR   = paddr;
  assign bus8.PWRITE  = pwrite;
  assign bus8.PSTRB   = pstrb;
  assign bus8.PWDATA  = pwdata;

  apb_gpio_ext #(.GPIO_WIDTH(32), .INPUT_STAGES(2), .DB_SAMPLES(4), .DB_PRESC_W(16)) dut (
    .PCLK(clk), .PRESET(preset), .bus(bus), .irq_o(irq),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe));

  apb_gpio_ext #(.GPIO_WIDTH(8), .INPUT_STAGES(2), .DB_SAMPLES(4), .DB_PRESC_W(16)) dut8 (
    .PCLK(clk), .PRESET(preset), .bus(bus8), .irq_o(irq8),
    .gpio_i(gpio8_i), .gpio_o(gpio8_o), .gpio_oe(gpio8_oe));

  task automatic apb_write(input logic [3:0] idx, input logic [31:0] data,
                           input logic [3:0] strb, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = {idx, 2'b00}; pwdata = data; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    err = tgt8 ? bus8.PSLVERR : bus.PSLVERR;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] idx, output logic [31:0] data, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {idx, 2'b00};
    @(negedge clk);
    penable = 1'b1;
    data = tgt8 ? bus8.PRDATA : bus.PRDATA;
    err  = tgt8 ? bus8.PSLVERR : bus.PSLVERR;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] data);
    logic err;
    apb_write(idx, data, 4'hF, err);
  endtask

  task automatic test_reset();
    logic exp_err;
    repeat (2) @(negedge clk);
    wr(4'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    preset = 1'b0;
    n_checks++; if (gpio_o !== 32'h0 || gpio_oe !== 32'h0) begin n_fail++; $display("FAIL reset_pads: got o=%h oe=%h want 0", gpio_o, gpio_oe); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_checks++; if (bus.PREADY !== 1'b1) begin n_fail++; $display("FAIL pready: got %b want 1", bus.PREADY); end
    for (int i = 0; i < 16; i++) begin
      apb_read(4'(i), d, e);
      exp_err = (i == 15) || (i >= 4 && i <= 6);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_read idx %0d: got %h want 0", i, d); end
      n_checks++; if (e !== exp_err) begin n_fail++; $display("FAIL reset_err idx %0d: got %b want %b", i, e, exp_err); end
    end
    apb_write(4'd3, 32'hFFFF_FFFF, 4'hF, e);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr_in_err: got %b want 1", e); end
    apb_write(4'd14, 32'hFFFF_FFFF, 4'hF, e);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr_irqstat_err: got %b want 1", e); end
    apb_write(4'd15, 32'hFFFF_FFFF, 4'hF, e);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr_idx15_err: got %b want 1", e); end
    apb_read(4'd14, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL irqstat_after_err: got %h want 0", d); end
    apb_read(4'd1, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL dir_after_reset_abort: got %h want 0", d); end
  endtask

  task automatic test_out_aliases();
    apb_write(4'd2, 32'h0000_00F0, 4'hF, e);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr_out_err: got %b want 0", e); end
    wr(4'd4, 32'h0000_000F);
    wr(4'd5, 32'h0000_0030);
    apb_write(4'd6, 32'h0000_0101, 4'b0001, e);
    n_checks++; if (gpio_o !== 32'h0000_00CF) begin n_fail++; $display("FAIL gpio_o_latency: got %h want %h", gpio_o, 32'h0000_00CF); end
    @(negedge clk);
    n_checks++; if (gpio_o !== 32'h0000_00CE) begin n_fail++; $display("FAIL gpio_o_follow: got %h want %h", gpio_o, 32'h0000_00CE); end
    apb_read(4'd2, d, e);
    n_checks++; if (d !== 32'h0000_00CE) begin n_fail++; $display("FAIL out_alias: got %h want %h", d, 32'h0000_00CE); end
    apb_write(4'd4, 32'h0000_FF00, 4'b0001, e);
    apb_read(4'd2, d, e);
    n_checks++; if (d !== 32'h0000_00CE) begin n_fail++; $display("FAIL set_strb_gate: got %h want %h", d, 32'h0000_00CE); end
    apb_write(4'd1, 32'hFFFF_FFFF, 4'b0010, e);
    apb_read(4'd1, d, e);
    n_checks++; if (d !== 32'h0000_FF00) begin n_fail++; $display("FAIL dir_strb: got %h want %h", d, 32'h0000_FF00); end
    n_checks++; if (gpio_oe !== 32'h0000_FF00) begin n_fail++; $display("FAIL gpio_oe_dir: got %h want %h", gpio_oe, 32'h0000_FF00); end
  endtask

  task automatic test_open_drain();
    wr(4'd2, 32'h1);
    wr(4'd1, 32'h1);
    wr(4'd0, 32'h1);
    @(negedge clk);
    n_checks++; if (gpio_oe !== 32'h0 || gpio_o !== 32'h0) begin n_fail++; $display("FAIL od_high: got oe=%h o=%h want 0", gpio_oe, gpio_o); end
    wr(4'd2, 32'h0);
    @(negedge clk);
    n_checks++; if (gpio_oe !== 32'h1) begin n_fail++; $display("FAIL od_low: got oe=%h want 1", gpio_oe); end
    wr(4'd0, 32'h0);
    wr(4'd1, 32'h0);
  endtask

  task automatic test_edge_trigger();
    wr(4'd7, 32'h8);
    wr(4'd8, 32'h8);
    wr(4'd9, 32'h8);
    wr(4'd11, 32'h8);
    apb_read(4'd10, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_idle: got %h want 0", d); end
    @(negedge clk);
    gpio_i[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", irq); end
      end
      if (k == 5) begin
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_latency: got %b want 1", irq); end
      end
    end
    apb_read(4'd10, d, e);
    n_checks++; if (d !== 32'h8) begin n_fail++; $display("FAIL tr_stat_rise: got %h want 8", d); end
    apb_read(4'd14, d, e);
    n_checks++; if (d !== 32'h8) begin n_fail++; $display("FAIL irq_stat_rise: got %h want 8", d); end
    wr(4'd10, 32'h8);
    apb_read(4'd10, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_w1c: got %h want 0", d); end
    gpio_i[3] = 1'b0;
    repeat (8) @(negedge clk);
    apb_read(4'd10, d, e);
    n_checks++; if (d !== 32'h8) begin n_fail++; $display("FAIL tr_stat_fall: got %h want 8", d); end
  endtask

  task automatic test_level_w1c();
    wr(4'd8, 32'h0);
    wr(4'd7, 32'h0);
    wr(4'd10, 32'h8);
    @(negedge clk);
    gpio_i[3] = 1'b1;
    repeat (6) @(negedge clk);
    wr(4'd10, 32'h8);
    apb_read(4'd10, d, e);
    n_checks++; if (d !== 32'h8) begin n_fail++; $display("FAIL w1c_vs_level: got %h want 8", d); end
    gpio_i[3] = 1'b0;
    repeat (6) @(negedge clk);
    wr(4'd10, 32'h8);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b want 1", irq); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop: got %b want 0", irq); end
    apb_read(4'd10, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h want 0", d); end
    wr(4'd11, 32'h0);
    wr(4'd9, 32'h0);
  endtask

  task automatic test_debounce();
    wr(4'd12, 32'h1);
    wr(4'd13, 32'd9);
    apb_read(4'd13, d, e);
    n_checks++; if (d !== 32'd9) begin n_fail++; $display("FAIL db_prescale: got %h want 9", d); end
    gpio_i[0] = 1'b1;
    repeat (25) @(negedge clk);
    gpio_i[0] = 1'b0;
    repeat (10) @(negedge clk);
    apb_read(4'd3, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL db_pulse: got %h want 0", d); end
    gpio_i[0] = 1'b1;
    repeat (24) @(negedge clk);
    apb_read(4'd3, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL db_early: got %h want 0", d); end
    repeat (24) @(negedge clk);
    apb_read(4'd3, d, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL db_accept: got %h want 1", d); end
    gpio_i[0] = 1'b0;
    wr(4'd12, 32'h0);
  endtask

  task automatic test_width8();
    tgt8 = 1'b1;
    wr(4'd1, 32'hFFFF_FFFF);
    apb_read(4'd1, d, e);
    n_checks++; if (d !== 32'h0000_00FF) begin n_fail++; $display("FAIL w8_dir: got %h want %h", d, 32'h0000_00FF); end
    n_checks++; if (gpio8_oe !== 8'hFF) begin n_fail++; $display("FAIL w8_oe: got %h want ff", gpio8_oe); end
    tgt8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_out_aliases();
    test_open_drain();
    test_edge_trigger();
    test_level_w1c();
    test_debounce();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_gpio_ext.md
Name: apb_gpio_ext

Overview:
- Parametrised next-generation APB3 GPIO peripheral. Configurable pin count, input synchroniser depth and per-pin debounce filter.
- Adds atomic SET/CLR/TOGGLE output aliases, a masked interrupt status register, and PSLVERR on illegal accesses.
- Sits on the peripheral APB bus; drives pad gpio_o/gpio_oe and a single level interrupt to the interrupt controller.

Parameters:
- GPIO_WIDTH, 32, number of pins, 1..32. Register bits >= GPIO_WIDTH read 0 and ignore writes.
- INPUT_STAGES, 2, synchroniser flops on gpio_i, >= 2.
- DB_SAMPLES, 4, consecutive stable prescaler ticks required to accept a debounced change, >= 1.
- DB_PRESC_W, 16, width of the DB_PRESCALE register.

Ports:
- PCLK  in  1  single clock.
- PRESET  in  1  synchronous active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PADDR  in  6  byte address; PADDR[5:2] is the register index, PADDR[1:0] ignored.
- PWRITE  in  1  write/read.
- PSTRB  in  4  byte strobes.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  error response.
- irq_o  out  1  interrupt.
- gpio_i  in  GPIO_WIDTH  pad inputs (asynchronous).
- gpio_o  out  GPIO_WIDTH  pad output values.
- gpio_oe  out  GPIO_WIDTH  pad output enables.

Behaviour:
- Reset: all registers, synchronisers, debounce state, prescaler, PRDATA, gpio_o, gpio_oe and irq_o are 0. Reset mid-transfer aborts the transfer with no register effect.
- Register map (index: name):
  - 0: MODE
  - 1: DIR
  - 2: OUT
  - 3: IN (RO)
  - 4: OUT_SET (WO)
  - 5: OUT_CLR (WO)
  - 6: OUT_TGL (WO)
  - 7: TR_TYPE
  - 8: TR_LVL0
  - 9: TR_LVL1
  - 10: TR_STAT (W1C)
  - 11: IRQ_ENA
  - 12: DB_ENA
  - 13: DB_PRESCALE
  - 14: IRQ_STAT (RO, = TR_STAT & IRQ_ENA)
  - 15: unmapped
- Zero-wait transfers; PREADY=1.
- Writes commit on PSEL&PENABLE&PWRITE. PSTRB gates each byte; a byte with PSTRB=0 is unchanged for every write type, including SET/CLR/TGL/W1C.
- OUT_SET: OUT |= data. OUT_CLR: OUT &= ~data. OUT_TGL: OUT ^= data.
- Reads: PRDATA is registered in the setup phase (PSEL&~PENABLE&~PWRITE) and stable through the access phase. WO registers read 0.
- PSLVERR=1 in the access phase for:
  - any access to index 15;
  - writes to IN or IRQ_STAT;
  - reads of WO registers.
  Errored writes have no effect. PSLVERR is 0 otherwise.
- Input path: gpio_i -> INPUT_STAGES synchroniser flops -> debounce -> IN register (1 flop).
  - DB_ENA[n]=0: IN[n] follows the synchroniser output with 1-cycle latency. Total gpio_i-to-IN latency is INPUT_STAGES+1 cycles.
  - DB_ENA[n]=1: the prescaler emits a tick every DB_PRESCALE+1 cycles; a DB_PRESCALE write restarts it. A per-pin counter increments on each tick while synced[n]!=IN[n] and clears when they are equal. IN[n] flips when the counter reaches DB_SAMPLES, and the counter then clears.
  - Toggling DB_ENA clears that pin's counter.
- Outputs (registered, 1 cycle after OUT/MODE/DIR change):
  - gpio_o[n] = MODE[n] ? 0 : OUT[n].
  - gpio_oe[n] = DIR[n] & ~(MODE[n] & OUT[n]). MODE=1 is open-drain.
- Triggers: dly <= IN each cycle.
  - Level (TR_TYPE[n]=0): hit = LVL0[n]&~IN[n] | LVL1[n]&IN[n].
  - Edge (TR_TYPE[n]=1): hit = LVL0[n]&dly[n]&~IN[n] | LVL1[n]&~dly[n]&IN[n]. Both set gives both edges.
  - TR_STAT <= (W1C-cleared TR_STAT) | hit. A set in the same cycle as a clear wins.
- irq_o <= |(TR_STAT & IRQ_ENA), registered. gpio_i edge to irq_o is INPUT_STAGES+3 cycles with debounce off.

Decomposition:
- Package apb_gpio_ext_pkg holds:
  - register index localparams/enum;
  - PADDR width;
  - helper functions for strobe merge (write, set, clear, toggle, W1C).
- Sub-module gpio_debounce (params WIDTH, DB_SAMPLES, DB_PRESC_W) contains the prescaler, per-pin counters and the IN register.

Test Plan:
- Reset, then read all 16 indices -> all return 0; index 15 PSLVERR=1; writes to IN and IRQ_STAT PSLVERR=1 with no state change.
- OUT=0x0000_00F0; SET 0x0F, CLR 0x30, TGL 0x101 with PSTRB=0001 -> OUT=0x0000_00CE; gpio_o follows 1 cycle later. MODE=1, OUT=1, DIR=1 on pin0 -> gpio_oe[0]=0.
- TR_TYPE[3]=1, LVL0[3]=LVL1[3]=1, IRQ_ENA[3]=1; gpio_i[3] rises -> TR_STAT=0x8 and irq_o=1 exactly 5 cycles after the input change (INPUT_STAGES=2).
- W1C 0x8 on TR_STAT while a level-1 trigger is still active on pin 3 -> bit remains 1. W1C again after the level drops -> bit 0, irq_o low next cycle.
- DB_ENA[0]=1, DB_PRESCALE=9; gpio_i[0] pulses high for 25 cycles -> IN[0] unchanged. Held high -> IN[0]=1 after 4 ticks (~40 cycles) +/- 10 cycles.
- GPIO_WIDTH=8 build: write 0xFFFF_FFFF to DIR -> reads back 0x0000_00FF.
